dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (async read, sync write, word-aligned) between two
//  requesters: port 0 = processor data port, port 1 = loader/accelerator port.
//  Round-robin arbitration, with optional locked bursts.
//  Sits between requesters and dmem in top; requester stalls while its gnt is low.
// PARAMETERS
//  DATA_W     32  data width of all data buses
//  ADDR_W     32  byte-address width, passed unmodified to memory
//  MAX_BURST  8   max consecutive locked beats per ownership (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high
//  req0/req1  in   1       access request, held until the beat completes
//  we0/we1    in   1       1 = write, 0 = read
//  lock0/lock1 in  1       keep ownership for the next beat (burst)
//  addr0/addr1 in  ADDR_W  byte address
//  wd0/wd1    in   DATA_W  write data
//  gnt0/gnt1  out  1       port owns memory this cycle; beat completes if reqN && gntN
//  rd0/rd1    out  DATA_W  read data, valid when gntN
//  mem_we     out  1       to dmem we
//  mem_a      out  ADDR_W  to dmem a
//  mem_wd     out  DATA_W  to dmem wd
//  mem_rd     in   DATA_W  from dmem rd (combinational)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  FSM states: IDLE, OWN0, OWN1.
//  gntN = (state==OWNN); outputs are decoded from state only, never from req.
//  Reset (async) -> IDLE, last=1 (port 0 wins first tie), beat_cnt=0.
//  Reset values: gnt0=gnt1=0, mem_we=0, mem_a=0, mem_wd=0, rd0=rd1=0, busy=0.
//  Reset asserted mid-burst: mem_we drops the same cycle; the partial burst is abandoned.
//  Memory mux:
//   - OWNN: mem_a=addrN, mem_wd=wdN, mem_we=reqN&weN, rdN=mem_rd, other rd=0.
//   - IDLE: mem_a/wd=0, mem_we=0.
//  Read data is combinational in the grant cycle (zero-wait dmem).
//   A write commits at the clock edge ending the beat.
//  Latency: IDLE->first grant is 1 cycle after req is sampled.
//   Back-to-back beats while owner: 1 per cycle.
//  IDLE: no req -> IDLE.
//   One req -> OWN(that port).
//   Both -> OWN(~last) (round robin).
//  OWNN, beat (reqN=1):
//   - lockN && beat_cnt<MAX_BURST-1 -> stay, beat_cnt++.
//   - else other req -> OWN(other), beat_cnt=0, last=N.
//   - else reqN still pending -> stay, beat_cnt=0 (work conserving).
//   - else -> IDLE, last=N.
//  OWNN, no beat (reqN=0): other req -> OWN(other), else IDLE; beat_cnt=0, last=N.
//  Burst cap: beat MAX_BURST of a locked burst forces a handover if the other port requests,
//   even with lockN=1.
//  The lock signal of a non-owner is ignored.
//  Simultaneous request arrival during handover: only state at the edge matters;
//   no beat is lost or duplicated.
//  beat_cnt width = $clog2(MAX_BURST)+1; it saturates, never wraps.
// STRUCTURE
//  Package dmem_arb_pkg: typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
//   typedef logic port_t.
//  Sub-module rr_pick: (req0, req1, last) -> winner, combinational tie-break.
//  The FSM, beat counter and memory mux stay in dmem_arbiter.
// TESTING
//  1. Reset, req0=1 we0=1 addr0=0x40 wd0=0xDEADBEEF -> cycle 1 gnt0=1 mem_we=1;
//     then read 0x40 returns rd0=0xDEADBEEF.
//  2. req0=req1=1 held, no lock -> grants alternate 0,1,0,1 (first 0 after reset); gnt never both.
//  3. lock1=1, req1 held 12 beats, req0=1, MAX_BURST=8 -> 8 gnt1 beats, then gnt0 for 1 beat,
//     then gnt1 resumes.
//  4. Only req1, addr sequence 0x0,0x4,0x8 -> 3 consecutive beats, no IDLE gap;
//     busy=0 after req1 drops.
//  5. Assert reset during OWN0 write burst -> same cycle gnt0=0, mem_we=0, busy=0;
//     memory word at the next burst address is unchanged.
//  6. req0 dropped without beat while OWN0, req1=1 -> next cycle gnt1=1; no mem_we in the gap.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OWN0, OWN1)
//   port_t      : requester index, 0 = processor data port, 1 = loader port
//   own_state() : maps a port index to the state in which that port owns memory
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_t;

    function automatic arb_state_t own_state(input port_t p);
        return p ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin tie-break between two requesters.
//   req0, req1 : pending requests
//   last       : port that most recently gave up ownership
//   winner     : port to grant (meaningful only when any=1)
//   any        : at least one request is pending
module rr_pick
    import dmem_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output port_t winner,
    output logic  any
);

    always_comb begin
        any = req0 | req1;
        // On a tie the port that did not own memory most recently wins.
        if (req0 && req1) begin
            winner = ~last;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (async read,
// sync write). Round-robin between the ports, with locked bursts capped
// at MAX_BURST consecutive beats per ownership.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   reqN, weN, lockN    : request, write enable, burst lock for port N
//   addrN, wdN          : byte address and write data for port N
//   gntN                : port N owns memory; a beat completes when reqN && gntN
//   rdN                 : read data for port N, valid while gntN, else 0
//   mem_we/mem_a/mem_wd : to dmem; mem_rd : combinational read data from dmem
//   busy                : arbiter is not idle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_t       state;
    port_t            last;
    logic [CNT_W-1:0] beat_cnt;

    port_t pick_winner;
    logic  pick_any;

    port_t owner;
    logic  own_req;
    logic  own_lock;
    logic  other_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    rr_pick u_rr_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Owner-relative view of the two ports; only meaningful outside IDLE.
    assign owner     = (state == OWN1);
    assign own_req   = owner ? req1  : req0;
    assign own_lock  = owner ? lock1 : lock0;
    assign other_req = owner ? req0  : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_any) begin
                        state <= own_state(pick_winner);
                    end
                end
                OWN0, OWN1: begin
                    if (own_req) begin
                        // A beat completes this cycle. The lock holds ownership only
                        // until the cap; the capping beat hands over if contended.
                        // With no contender the owner keeps memory even if it goes
                        // quiet; the idle return happens on the following no-beat cycle.
                        if (own_lock && (beat_cnt < CNT_LAST)) begin
                            beat_cnt <= sat_inc(beat_cnt);
                        end else if (other_req) begin
                            state    <= own_state(~owner);
                            beat_cnt <= '0;
                            last     <= owner;
                        end else begin
                            beat_cnt <= '0;
                        end
                    end else begin
                        state    <= other_req ? own_state(~owner) : IDLE;
                        beat_cnt <= '0;
                        last     <= owner;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Grants and the memory mux decode from the state register only, so an
    // asynchronous reset removes the grant and the write strobe immediately.
    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign busy = (state != IDLE);

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        rd0    = '0;
        rd1    = '0;
        case (state)
            OWN0: begin
                mem_we = req0 & we0;
                mem_a  = addr0;
                mem_wd = wd0;
                rd0    = mem_rd;
            end
            OWN1: begin
                mem_we = req1 & we1;
                mem_a  = addr1;
                mem_wd = wd1;
                rd1    = mem_rd;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-port requester drivers, a dmem
// model, and a scoreboard of expected beats checked by a negedge monitor.
module tb_dmem_arbiter;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BURST = 8;

    logic              clk;
    logic              reset;
    logic              req0, we0, lock0, req1, we1, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              gnt0, gnt1, mem_we, busy;
    logic [DATA_W-1:0] rd0, rd1, mem_wd, mem_rd;
    logic [ADDR_W-1:0] mem_a;

    typedef struct {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    cmd_t cq0[$];
    cmd_t cq1[$];
    exp_t exp_q[$];

    logic [31:0] mem [0:255];
    logic        beat0_s, beat1_s;
    int          n_checks;
    int          n_fail;

    dmem_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .we0    (we0),
        .lock0  (lock0),
        .addr0  (addr0),
        .wd0    (wd0),
        .req1   (req1),
        .we1    (we1),
        .lock1  (lock1),
        .addr1  (addr1),
        .wd1    (wd1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rd0    (rd0),
        .rd1    (rd1),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem model: async read, write at the rising edge; word i preloaded with A5A5_00ii.
    assign mem_rd = mem[mem_a[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_a[9:2]] = mem_wd;
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Requesters: present the head command, hold it until its beat completes.
    initial begin
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wd0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wd1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cq0.delete();
                cq1.delete();
            end else begin
                if (beat0_s && cq0.size() > 0) void'(cq0.pop_front());
                if (beat1_s && cq1.size() > 0) void'(cq1.pop_front());
            end
            if (cq0.size() > 0) begin
                req0 = 1; we0 = cq0[0].we; lock0 = cq0[0].lock; addr0 = cq0[0].addr; wd0 = cq0[0].wd;
            end else begin
                req0 = 0; we0 = 0; lock0 = 0;
            end
            if (cq1.size() > 0) begin
                req1 = 1; we1 = cq1[0].we; lock1 = cq1[0].lock; addr1 = cq1[0].addr; wd1 = cq1[0].wd;
            end else begin
                req1 = 0; we1 = 0; lock1 = 0;
            end
        end
    end

    // Monitor: every completed beat must match the head of the expected queue.
    initial begin
        beat0_s = 0;
        beat1_s = 0;
        forever begin
            @(negedge clk);
            beat0_s = !reset && req0 && gnt0;
            beat1_s = !reset && req1 && gnt1;
            if (beat0_s || beat1_s) begin
                check("one_grant", {63'd0, gnt0 & gnt1}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_port", {63'd0, gnt1}, {63'd0, e.port});
                    check("beat_addr", {32'd0, mem_a}, {32'd0, e.addr});
                    check("beat_we", {63'd0, mem_we}, {63'd0, e.we});
                    if (e.we) begin
                        check("beat_wdata", {32'd0, mem_wd}, {32'd0, e.data});
                    end else begin
                        check("beat_rdata", {32'd0, (gnt1 ? rd1 : rd0)}, {32'd0, e.data});
                        check("beat_rd_other", {32'd0, (gnt1 ? rd0 : rd1)}, 64'd0);
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic p, input logic we, input logic lock,
                            input logic [31:0] addr, input logic [31:0] wd);
        cmd_t c;
        c.we = we; c.lock = lock; c.addr = addr; c.wd = wd;
        if (p) cq1.push_back(c);
        else   cq0.push_back(c);
    endtask

    task automatic push_exp(input logic p, input logic we, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.port = p; e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1;
        repeat (2) @(posedge clk);
        #3 reset = 0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || cq0.size() != 0 || cq1.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_gnt(input logic p, input int max);
        int n = 0;
        @(posedge clk);
        #3;
        while (!(p ? gnt1 : gnt0) && n < max) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("wait_gnt", {63'd0, (p ? gnt1 : gnt0)}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_a", {32'd0, mem_a}, 64'd0);
        check("rst_mem_wd", {32'd0, mem_wd}, 64'd0);
        check("rst_rd", {rd0, rd1}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 0;
        @(posedge clk);
        #3;
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Write then read back through port 0; grant one cycle after req is sampled.
        push_cmd(0, 1, 0, 32'h40, 32'hDEADBEEF);
        push_cmd(0, 0, 0, 32'h40, 32'h0);
        push_exp(0, 1, 32'h40, 32'hDEADBEEF);
        push_exp(0, 0, 32'h40, 32'hDEADBEEF);
        @(posedge clk);
        #3;
        check("t1_no_early_gnt", {63'd0, gnt0}, 64'd0);
        @(posedge clk);
        #3;
        check("t1_gnt0", {63'd0, gnt0}, 64'd1);
        check("t1_mem_we", {63'd0, mem_we}, 64'd1);
        wait_drain(20);

        // Both ports contend without lock: strict alternation starting with port 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 0, 0, 32'h100 + 4 * i, 32'h0);
            push_cmd(1, 0, 0, 32'h180 + 4 * i, 32'h0);
            push_exp(0, 0, 32'h100 + 4 * i, 32'hA5A5_0040 + i);
            push_exp(1, 0, 32'h180 + 4 * i, 32'hA5A5_0060 + i);
        end
        wait_drain(40);

        // Locked burst on port 1 is capped at MAX_BURST beats when port 0 waits.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            push_cmd(1, 1, 1, 32'h200 + 4 * i, 32'h1000 + i);
        end
        for (int i = 0; i < 8; i++) push_exp(1, 1, 32'h200 + 4 * i, 32'h1000 + i);
        push_exp(0, 0, 32'hA0, 32'hA5A5_0028);
        for (int i = 8; i < 12; i++) push_exp(1, 1, 32'h200 + 4 * i, 32'h1000 + i);
        wait_gnt(1, 10);
        push_cmd(0, 0, 0, 32'hA0, 32'h0);
        wait_drain(60);
        check("t3_mem_last", {32'd0, mem[139]}, 64'h100B);

        // Single requester streams back-to-back beats, then the arbiter idles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_cmd(1, 0, 0, 32'h4 * i, 32'h0);
            push_exp(1, 0, 32'h4 * i, 32'hA5A5_0000 + i);
        end
        wait_gnt(1, 10);
        check("t4_beat1", {63'd0, gnt1 & req1}, 64'd1);
        @(posedge clk);
        #3;
        check("t4_beat2", {63'd0, gnt1 & req1 & busy}, 64'd1);
        @(posedge clk);
        #3;
        check("t4_beat3", {63'd0, gnt1 & req1 & busy}, 64'd1);
        repeat (2) @(posedge clk);
        #3;
        check("t4_busy_off", {63'd0, busy}, 64'd0);
        wait_drain(10);

        // Reset in the middle of a locked write burst abandons the remaining beats.
        do_reset();
        for (int i = 0; i < 4; i++) push_cmd(0, 1, 1, 32'h300 + 4 * i, 32'h5000 + i);
        push_exp(0, 1, 32'h300, 32'h5000);
        wait_gnt(0, 10);
        @(posedge clk);
        #3;
        check("t5_pre_we", {63'd0, mem_we}, 64'd1);
        reset = 1;
        #1;
        check("t5_gnt0", {63'd0, gnt0}, 64'd0);
        check("t5_mem_we", {63'd0, mem_we}, 64'd0);
        check("t5_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 0;
        check("t5_first_written", {32'd0, mem[192]}, 64'h5000);
        check("t5_next_unchanged", {32'd0, mem[193]}, 64'hA5A5_00C1);
        wait_drain(5);

        // Owner goes quiet while port 1 arrives: one no-write gap, then handover.
        do_reset();
        push_cmd(0, 1, 0, 32'h80, 32'h66);
        push_exp(0, 1, 32'h80, 32'h66);
        wait_gnt(0, 10);
        push_cmd(1, 0, 0, 32'h84, 32'h0);
        push_exp(1, 0, 32'h84, 32'hA5A5_0021);
        @(posedge clk);
        #3;
        check("t6_gap_gnt0", {63'd0, gnt0}, 64'd1);
        check("t6_gap_no_we", {63'd0, mem_we}, 64'd0);
        @(posedge clk);
        #3;
        check("t6_gnt1", {63'd0, gnt1}, 64'd1);
        wait_drain(10);
        check("t6_mem_written", {32'd0, mem[32]}, 64'h66);

        check("final_queue", exp_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
